// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial prefix adder:
// FSM states, the (G,P) dot operator and digit-count sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // High operand first: G = gh | ph&gl, P = ph&pl.
    function automatic logic [1:0] dot(input logic gh, input logic ph,
                                       input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    localparam int WIDTH_DEF = 16;
    localparam int DIGIT_DEF = 4;
    localparam int NDIG      = WIDTH_DEF / DIGIT_DEF;
    localparam int CNT_W     = cnt_width(NDIG);

endpackage

// File: rtl/digit_prefix_unit.sv
// Combinational Kogge-Stone digit slice: resolves intra-digit carries from
// the incoming carry and reports the digit's group generate/propagate.
module digit_prefix_unit
    import adder_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             Gd,
    output logic             Pd
);

    localparam int LEVELS = (DIGIT > 1) ? $clog2(DIGIT) : 0;

    genvar lv, bi;
    for (lv = 0; lv <= LEVELS; lv++) begin : g_stage
        logic [DIGIT-1:0] w_g;
        logic [DIGIT-1:0] w_p;
        if (lv == 0) begin : g_init
            assign w_g = a_d & b_d;
            assign w_p = a_d ^ b_d;
        end else begin : g_comb
            for (bi = 0; bi < DIGIT; bi++) begin : g_bit
                if (bi >= (2 ** (lv - 1))) begin : g_dot
                    assign {w_g[bi], w_p[bi]} = dot(g_stage[lv-1].w_g[bi],
                                                    g_stage[lv-1].w_p[bi],
                                                    g_stage[lv-1].w_g[bi-(2**(lv-1))],
                                                    g_stage[lv-1].w_p[bi-(2**(lv-1))]);
                end else begin : g_pass
                    assign w_g[bi] = g_stage[lv-1].w_g[bi];
                    assign w_p[bi] = g_stage[lv-1].w_p[bi];
                end
            end
        end
    end

    logic [DIGIT-1:0] w_gPre;
    logic [DIGIT-1:0] w_pPre;
    logic [DIGIT-1:0] w_carry;

    assign w_gPre = g_stage[LEVELS].w_g;
    assign w_pPre = g_stage[LEVELS].w_p;

    // Carry into bit i is the prefix over bits [i-1:0] applied to cin.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = cin;
        for (int i = 1; i < DIGIT; i++) begin
            w_carry[i] = w_gPre[i-1] | (w_pPre[i-1] & cin);
        end
    end

    assign s_d   = g_stage[0].w_p ^ w_carry;
    assign Gd    = w_gPre[DIGIT-1];
    assign Pd    = w_pPre[DIGIT-1];
    assign c_out = Gd | (Pd & cin);

endmodule

// File: rtl/serial_prefix_adder.sv
// Digit-serial adder: one DIGIT-wide slice per cycle, LS digit first, with an
// optional end-around-carry pass for modulo 2^WIDTH-1 addition.
module serial_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mod_m1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             gout,
    output logic             pout
);

    localparam int                LNDIG  = WIDTH / DIGIT;
    localparam int                LCNT_W = cnt_width(LNDIG);
    localparam logic [LCNT_W-1:0] LAST   = LCNT_W'(LNDIG - 1);

    state_t              r_state;
    logic [LCNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]    r_opA;
    logic [WIDTH-1:0]    r_opB;
    logic                r_mod;
    logic                r_carry;
    logic                r_gAcc;
    logic                r_pAcc;

    logic [DIGIT-1:0]    w_aDig;
    logic [DIGIT-1:0]    w_bDig;
    logic [DIGIT-1:0]    w_sDig;
    logic                w_cOut;
    logic                w_gd;
    logic                w_pd;
    logic [WIDTH-1:0]    w_sumNext;

    assign w_aDig = r_opA[r_cnt*DIGIT +: DIGIT];
    assign w_bDig = r_opB[r_cnt*DIGIT +: DIGIT];

    always_comb begin
        w_sumNext                          = sum;
        w_sumNext[r_cnt*DIGIT +: DIGIT]    = w_sDig;
    end

    digit_prefix_unit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d   (w_aDig),
        .b_d   (w_bDig),
        .cin   (r_carry),
        .s_d   (w_sDig),
        .c_out (w_cOut),
        .Gd    (w_gd),
        .Pd    (w_pd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_mod     <= 1'b0;
            r_carry   <= 1'b0;
            r_gAcc    <= 1'b0;
            r_pAcc    <= 1'b1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            gout      <= 1'b0;
            pout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opA    <= a;
                        r_opB    <= b;
                        r_mod    <= mod_m1;
                        r_carry  <= mod_m1 ? 1'b0 : cin;
                        r_gAcc   <= 1'b0;
                        r_pAcc   <= 1'b1;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    sum     <= w_sumNext;
                    r_carry <= w_cOut;
                    {r_gAcc, r_pAcc} <= dot(w_gd, w_pd, r_gAcc, r_pAcc);
                    if (r_cnt == LAST) begin
                        cout         <= w_cOut;
                        {gout, pout} <= dot(w_gd, w_pd, r_gAcc, r_pAcc);
                        r_cnt        <= '0;
                        // End-around carry: re-add 1 to the first-pass sum.
                        if (r_mod && w_cOut) begin
                            r_opA   <= w_sumNext;
                            r_opB   <= '0;
                            r_carry <= 1'b1;
                            r_state <= FIX;
                        end else begin
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + LCNT_W'(1);
                    end
                end
                FIX: begin
                    sum     <= w_sumNext;
                    r_carry <= w_cOut;
                    if (r_cnt == LAST) begin
                        r_cnt     <= '0;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + LCNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_prefix_adder.sv
// Directed bench for serial_prefix_adder: arithmetic reference model plus
// literal expectations, handshake latency, backpressure and async reset.
module tb_serial_prefix_adder;
    import adder_pkg::*;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         mod_m1    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         gout;
    logic         pout;

    int           checks = 0;
    int           errors = 0;

    logic         expValid = 1'b0;
    logic [W-1:0] expSum   = '0;
    logic         expCout  = 1'b0;
    logic         expGout  = 1'b0;
    logic         expPout  = 1'b0;

    always #5 clk = ~clk;

    serial_prefix_adder #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mod_m1    (mod_m1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .gout      (gout),
        .pout      (pout)
    );

    // Reference: {cout, gout, pout, sum} from plain integer addition.
    function automatic logic [W+2:0] modelAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic m);
        logic [W:0] first;
        logic [W:0] noCin;
        logic [W:0] result;
        first  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, (m ? 1'b0 : c)};
        noCin  = {1'b0, x} + {1'b0, y};
        result = first;
        if (m && first[W]) result = {1'b0, first[W-1:0]} + (W+1)'(1);
        return {first[W], noCin[W], &(x ^ y), result[W-1:0]};
    endfunction

    function automatic int modelLatency(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic m);
        logic [W:0] first;
        first = {1'b0, x} + {1'b0, y};
        return (m && first[W]) ? 2 * NDIG : NDIG;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whenever a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!expValid) begin
                checkOutput("spurious out_valid", W'(out_valid), W'(1'b0));
            end else begin
                checkOutput("model sum", sum, expSum);
                checkOutput("model cout", W'(cout), W'(expCout));
                checkOutput("model gout", W'(gout), W'(expGout));
                checkOutput("model pout", W'(pout), W'(expPout));
                checkOutput("in_ready while busy", W'(in_ready), W'(1'b0));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic m, input int hold,
                                 input bit lit, input logic [W-1:0] lSum,
                                 input logic lCout, input logic lGout, input logic lPout,
                                 input int lLat);
        logic [W+2:0] r;
        int           cycles;
        r      = modelAdd(x, y, c, m);
        cycles = 0;
        while (!in_ready && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("in_ready before accept", W'(in_ready), W'(1'b1));
        {expCout, expGout, expPout, expSum} = r;
        expValid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        mod_m1   = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~x;
        b        = ~y;
        cin      = ~c;
        mod_m1   = ~m;
        cycles   = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("latency", W'(cycles), W'(lit ? lLat : modelLatency(x, y, m)));
        if (lit) begin
            checkOutput("literal sum", sum, lSum);
            checkOutput("literal cout", W'(cout), W'(lCout));
            checkOutput("literal gout", W'(gout), W'(lGout));
            checkOutput("literal pout", W'(pout), W'(lPout));
        end
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin
                in_valid = 1'b1;
                a        = 16'h7777;
                b        = 16'h1111;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            checkOutput("out_valid held", W'(out_valid), W'(1'b1));
            checkOutput("sum held", sum, lSum);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        expValid  = 1'b0;
        checkOutput("out_valid after ready", W'(out_valid), W'(1'b0));
        checkOutput("in_ready after ready", W'(in_ready), W'(1'b1));
    endtask

    initial begin
        #12;
        checkOutput("reset in_ready", W'(in_ready), W'(1'b1));
        checkOutput("reset out_valid", W'(out_valid), W'(1'b0));
        checkOutput("reset sum", sum, W'(0));
        checkOutput("reset cout", W'(cout), W'(1'b0));
        checkOutput("reset gout", W'(gout), W'(1'b0));
        checkOutput("reset pout", W'(pout), W'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4);
        applyStimulus(16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
        applyStimulus(16'h8000, 16'h8001, 1'b1, 1'b1, 0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 8);
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b1, 0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 1'b0, 5, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(16'h2222, 16'h1111, 1'b1, 1'b0, 0, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(16'hABCD, 16'h1234, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(16'h9E37, 16'h79B9, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 8);

        // Abort an operation two digits in; outputs must clear without a clock edge.
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        mod_m1   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort in_ready", W'(in_ready), W'(1'b1));
        checkOutput("abort out_valid", W'(out_valid), W'(1'b0));
        checkOutput("abort sum", sum, W'(0));
        checkOutput("abort cout", W'(cout), W'(1'b0));
        checkOutput("abort gout", W'(gout), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_prefix_adder.md
Name: serial_prefix_adder

Overview:
- Digit-serial adder built around the (G,P) dot combine. Consumes full-width operands over a valid/ready handshake and processes DIGIT bits per cycle, least-significant digit first.
- Each cycle it resolves intra-digit carries with a small prefix tree and folds the digit's group (G,P) into a running accumulator.
- It is the consumer end of group generate/propagate: it turns (G,P) into carries, sum bits and a whole-word group (G,P).
- Optional mod 2^WIDTH-1 mode adds an end-around-carry pass.

Parameters:
WIDTH, 16, operand/sum width; must be a multiple of DIGIT
DIGIT, 4, bits processed per cycle; NDIG = WIDTH/DIGIT cycles per pass

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when mod_m1=1
mod_m1  input  1  1 = add modulo 2^WIDTH-1 (end-around carry)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of first pass
gout  output  1  word group generate of a,b (carry-out with cin=0)
pout  output  1  word group propagate, &(a^b)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, gout=0, pout=0. Internal: digit counter 0, carry reg 0, Gacc=0, Pacc=1.
- States:
  - IDLE: in_ready=1. On in_valid: latch a, b, mod_m1; carry reg <= (mod_m1 ? 0 : cin); Gacc=0; Pacc=1; cnt=0; go to CALC.
  - CALC: per cycle, digit d = operand bits [cnt*DIGIT +: DIGIT]. Bitwise g=a&b, p=a^b. Prefix-combine within the digit; carry into each bit = digit prefix G | prefix P & carry reg. Write sum bits of digit d. Then carry reg <= digit carry-out; Gacc <= Gd | Pd&Gacc; Pacc <= Pd&Pacc. On cnt==NDIG-1: cout/gout/pout capture final values. If mod_m1 && carry-out==1, go to FIX; otherwise go to DONE.
  - FIX: second pass reusing the digit datapath, with A := first-pass sum, B := 0, carry reg := 1, cnt restarted at 0. Runs NDIG cycles, then goes to DONE. Cannot overflow. cout/gout/pout keep their first-pass values.
  - DONE: out_valid=1; sum, cout, gout, pout held stable. On out_ready: out_valid drops next cycle and state returns to IDLE.
- in_ready is 1 only in IDLE; no overlap between operations.
- Latency, accept edge to out_valid high: NDIG cycles, or 2*NDIG when FIX runs.
- In mod mode an all-ones result is the second representation of zero; it is emitted as-is, with no normalisation.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored, and the operands are not sampled.
- Reset mid-operation (any state) aborts immediately: all outputs and state return to reset values, and the partial result is discarded.
- Group accumulator order: the newly processed (higher) digit is the high operand of the dot, the accumulator the low operand. So Ghl = Gh | Ph&Gl and Phl = Ph&Pl.

Decomposition:
- Shared package `adder_pkg`:
  - state enum (IDLE, CALC, FIX, DONE);
  - function `dot(gh,ph,gl,pl)` returning {G,P};
  - localparam NDIG and the counter width $clog2(NDIG).
- One sub-module `digit_prefix_unit` (parameter DIGIT):
  - inputs: a_d, b_d, cin;
  - outputs: s_d, c_out, Gd, Pd;
  - combinational Kogge-Stone built from `dot`.
- Top holds the FSM, counter, operand/sum registers, carry reg and accumulators.

Test Plan:
1. WIDTH=16, DIGIT=4, a=0x1234, b=0x4321, cin=0, mod=0 -> sum=0x5555, cout=0, gout=0, pout=0; out_valid exactly 4 cycles after accept.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, gout=1, pout=0; latency 4.
3. a=0xF0F0, b=0x0F0F, cin=1 -> sum=0x0000, cout=1, gout=0, pout=1 (carry rippled through propagate digits).
4. mod=1, a=0x8000, b=0x8001, cin=1 (ignored) -> FIX pass, sum=0x0002, cout=1, latency 8. Then mod=1, a=0x0001, b=0x0002 -> sum=0x0003, latency 4.
5. Backpressure: result ready, out_ready=0 for 5 cycles -> outputs stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle; the next operand is accepted on the following cycle.
6. rst_n asserted at CALC cnt=2 -> outputs zero and in_ready=1 asynchronously. After release, a=0x0001, b=0x0001 -> sum=0x0002, cout=0, latency 4.
